// File: rtl/hue_to_rgb.sv
// hue_to_rgb: pipelined full-saturation HSV colour mapper (hue + amplitude -> RGB).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   noteHue_i [D]      hue, 0..2^D-1 spans one colour circle, 0 = red
//   amplitude_i [AW]   HSV value
//   in_valid/in_ready  input handshake (in_ready combinational from out_valid/out_ready)
//   red_o/green_o/blue_o [AW], out_valid/out_ready  output beat and handshake
// Define HUE_GAMMA_EN to add a fourth squaring (gamma) stage; latency becomes 4.
module hue_to_rgb #(
    parameter int D  = 10,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [D-1:0]  noteHue_i,
    input  logic [AW-1:0] amplitude_i,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] red_o,
    output logic [AW-1:0] green_o,
    output logic [AW-1:0] blue_o,
    output logic          out_valid,
    input  logic          out_ready
);
    logic          advance;
    logic          v1, v2, v3;
    logic [2:0]    sec1, sec2;
    logic [D-1:0]  frac1;
    logic [AW-1:0] amp1, amp2, rise2, fall2;
    logic [AW-1:0] r3, g3, b3;
    logic [D+2:0]  s;
    logic [AW-1:0] rise;
    logic [AW-1:0] r_mux, g_mux, b_mux;

    // Whole pipeline moves together; an empty output slot always lets bubbles collapse.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign s        = {3'b000, noteHue_i} * (D+3)'(6);
    assign rise     = AW'(({{D{1'b0}}, amp1} * {{AW{1'b0}}, frac1}) >> D);

    always_comb begin
        r_mux = (sec2 == 3'd0 || sec2 == 3'd5) ? amp2 : sec2 == 3'd1 ? fall2 : sec2 == 3'd4 ? rise2 : '0;
        g_mux = (sec2 == 3'd1 || sec2 == 3'd2) ? amp2 : sec2 == 3'd0 ? rise2 : sec2 == 3'd3 ? fall2 : '0;
        b_mux = (sec2 == 3'd3 || sec2 == 3'd4) ? amp2 : sec2 == 3'd2 ? rise2 : sec2 == 3'd5 ? fall2 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            sec1  <= '0;
            frac1 <= '0;
            amp1  <= '0;
            sec2  <= '0;
            amp2  <= '0;
            rise2 <= '0;
            fall2 <= '0;
            r3    <= '0;
            g3    <= '0;
            b3    <= '0;
        end else if (advance) begin
            v1    <= in_valid;
            sec1  <= s[D+2:D];
            frac1 <= s[D-1:0];
            amp1  <= amplitude_i;
            v2    <= v1;
            sec2  <= sec1;
            amp2  <= amp1;
            rise2 <= rise;
            fall2 <= amp1 - rise;
            v3    <= v2;
            r3    <= r_mux;
            g3    <= g_mux;
            b3    <= b_mux;
        end
    end

`ifdef HUE_GAMMA_EN
    logic          v4;
    logic [AW-1:0] r4, g4, b4;

    function automatic logic [AW-1:0] sq_hi(input logic [AW-1:0] c);
        return AW'(({{AW{1'b0}}, c} * {{AW{1'b0}}, c}) >> AW);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            v4 <= 1'b0;
            r4 <= '0;
            g4 <= '0;
            b4 <= '0;
        end else if (advance) begin
            v4 <= v3;
            r4 <= sq_hi(r3);
            g4 <= sq_hi(g3);
            b4 <= sq_hi(b3);
        end
    end

    assign out_valid = v4;
    assign red_o     = r4;
    assign green_o   = g4;
    assign blue_o    = b4;
`else
    assign out_valid = v3;
    assign red_o     = r3;
    assign green_o   = g3;
    assign blue_o    = b3;
`endif
endmodule

// File: tb/tb_hue_to_rgb.sv
// tb_hue_to_rgb: scoreboard bench for hue_to_rgb.
module tb_hue_to_rgb;
    localparam int D  = 10;
    localparam int AW = 8;
`ifdef HUE_GAMMA_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [D-1:0]  hue = '0;
    logic [AW-1:0] amp = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] red, green, blue;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3*AW-1:0] exp_rgb = '0;
    logic [3*AW-1:0] sb[$];
    int checks = 0;
    int errors = 0;

    hue_to_rgb #(.D(D), .AW(AW)) dut (
        .clk(clk), .rst(rst), .noteHue_i(hue), .amplitude_i(amp),
        .in_valid(in_valid), .in_ready(in_ready),
        .red_o(red), .green_o(green), .blue_o(blue),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [3*AW-1:0] model(input int h, input int a);
        int s = h * 6;
        int sec = s / (1 << D);
        int fr = s % (1 << D);
        int ri = (a * fr) / (1 << D);
        int fa = a - ri;
        int r = 0, g = 0, b = 0;
        case (sec)
            0: begin r = a;  g = ri; end
            1: begin r = fa; g = a;  end
            2: begin g = a;  b = ri; end
            3: begin g = fa; b = a;  end
            4: begin r = ri; b = a;  end
            default: begin r = a; b = fa; end
        endcase
`ifdef HUE_GAMMA_EN
        r = (r * r) / (1 << AW);
        g = (g * g) / (1 << AW);
        b = (b * b) / (1 << AW);
`endif
        return {r[AW-1:0], g[AW-1:0], b[AW-1:0]};
    endfunction

    // Decide at the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
                else check("beat_rgb", 32'({red, green, blue}), 32'(sb.pop_front()));
            end
            if (in_valid && in_ready) sb.push_back(exp_rgb);
        end
    end

    task automatic send(input int h, input int a, input logic [3*AW-1:0] e);
        logic rdy;
        int t = 0;
        hue = D'(h);
        amp = AW'(a);
        exp_rgb = e;
        in_valid = 1'b1;
        forever begin
            @(negedge clk) rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (++t > 100) begin
                check("send_timeout", 32'(t), 32'd0);
                break;
            end
        end
    endtask

    task automatic send_m(input int h, input int a);
        send(h, a, model(h, a));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while (sb.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [3*AW-1:0] snap;
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        idle(1);

        // Latency and single-cycle presentation of one beat.
`ifdef HUE_GAMMA_EN
        send(0, 255, {8'd254, 8'd0, 8'd0});
`else
        send(0, 255, {8'd255, 8'd0, 8'd0});
`endif
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        @(posedge clk);
        #1;
        check("one_cycle_valid", 32'(out_valid), 32'd0);

        // Directed colours and boundaries, back to back.
`ifdef HUE_GAMMA_EN
        send(256, 255, {8'd64, 8'd254, 8'd0});
        send(512, 255, {8'd0, 8'd254, 8'd254});
        send(1023, 255, {8'd254, 8'd0, 8'd0});
`else
        send(256, 255, {8'd128, 8'd255, 8'd0});
        send(512, 255, {8'd0, 8'd255, 8'd255});
        send(1023, 255, {8'd255, 8'd0, 8'd2});
`endif
        send(0, 0, '0);
        send(700, 0, '0);
        send(1023, 0, '0);
        drain();

        // Random beats with random backpressure.
        fork
            begin
                for (int i = 0; i < 30; i++) send_m($urandom_range(0, 1023), $urandom_range(0, 255));
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Stream 6 beats with a long output stall.
        fork
            begin
                for (int i = 0; i < 6; i++) send_m(100 + 150 * i, 200 - 10 * i);
                in_valid = 1'b0;
            end
            begin
                bit have = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk);
                    #1;
                    if (have) begin
                        check("stall_frozen_rgb", 32'({red, green, blue}), 32'(snap));
                        check("stall_valid", 32'(out_valid), 32'd1);
                        check("stall_in_ready", 32'(in_ready), 32'd0);
                    end else if (out_valid) begin
                        snap = {red, green, blue};
                        have = 1'b1;
                    end
                end
                check("stall_seen_valid", 32'(have), 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        send_m(300, 180);
        send_m(600, 90);
        send_m(900, 255);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rgb", 32'({red, green, blue}), 32'd0);
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) n++;
        end
        check("stale_beats", 32'(n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
